shift_ex_stage: RTL and testbench
=================================

Name: shift_ex_stage

Overview:
- Two-stage elastic execute pipeline for the 16-bit shift datapath.
- Sits between the decode/issue logic and writeback.
- Stage 1 registers the issued shift operation: operand, shift amount, opcode and destination tag.
- Stage 2 registers the computed SLL/SRA/ROR result with its Z flag and tag. Backpressure uses valid/ready handshakes on both sides, plus a pipeline flush.

Parameters:
- DW, 16, datapath width; power of two only.
- SW, 4, shift-amount width; equals log2(DW).
- TW, 4, destination register tag width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  discard all in-flight operations.
- in_valid  in  1  upstream offers an operation.
- in_ready  out  1  stage 1 can accept this cycle.
- in_data  in  DW  operand to shift.
- in_amt  in  SW  shift amount, 0..DW-1.
- in_op  in  2  operation: 00 SLL, 01 SRA, 10 ROR, 11 illegal.
- in_tag  in  TW  destination tag, carried unchanged.
- out_valid  out  1  stage 2 holds a result.
- out_ready  in  1  downstream consumes this cycle.
- out_data  out  DW  shift result.
- out_tag  out  TW  tag of the result.
- out_z  out  1  high when out_data == 0.
- out_err  out  1  the operation had the illegal opcode.

Behaviour:
- Reset (rst_n low, asynchronous): all valid bits and all stage registers clear to 0. in_ready is 1 once rst_n is high, because the pipeline is empty. out_valid, out_data, out_tag, out_z and out_err are all 0.
- Handshakes:
  - Input accept occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
  - out_data, out_tag, out_z and out_err stay stable while out_valid && !out_ready.
- Stall logic:
  - s2_free = !s2_valid || out_ready.
  - s1_adv = s1_valid && s2_free.
  - in_ready = !flush && (!s1_valid || s1_adv).
  - This is a combinational path from out_ready to in_ready, and it is intended.
- Latency and throughput:
  - An op accepted at edge N appears on out_valid after edge N+1, assuming no stall.
  - Sustained throughput is 1 op per cycle when out_ready is held high.
- Stage 2 computation (combinational from the stage-1 registers, captured on s1_adv):
  - SLL: zero-fill left shift by amt.
  - SRA: sign-fill right shift by amt, replicating bit DW-1.
  - ROR: rotate right by amt. amt = 0 returns the operand.
  - Illegal op (11): result = operand unshifted, err = 1.
  - z = (result == 0), computed on the captured result. An illegal op with zero operand gives z = 1.
  - amt = 0 returns the operand for every opcode.
- Valid updates:
  - s1_valid takes the value of the input accept if an accept occurs; otherwise it clears when s1_adv.
  - s2_valid sets on s1_adv and clears on an output transfer when no s1_adv occurs in the same cycle.
  - A simultaneous output transfer and s1_adv replaces the stage-2 contents in the same edge.
- Flush (synchronous, highest priority):
  - On the edge where flush = 1, s1_valid and s2_valid both clear.
  - in_ready is 0 during the flush cycle, so no accept occurs.
  - An output transfer in the flush cycle still counts as delivered, since out_valid && out_ready was true.
  - out_valid is 0 in the cycle after the flush edge.
- Ordering: strict in-order delivery. No op is duplicated, dropped (except by flush) or reordered under any stall pattern.
- Data registers do not need clearing when a valid bit drops. Outputs are meaningful only when out_valid = 1, except at reset, where they read 0.
- Reset asserted mid-operation discards all contents immediately. Operation resumes from the empty state after rst_n deasserts.

Test Plan:
- SLL, in_data = 0x0001, amt = 4, tag 3, out_ready = 1 -> two cycles later out_data = 0x0010, out_tag = 3, out_z = 0, out_err = 0.
- SRA 0x8000 by 15 -> 0xFFFF. SRA 0x7FFF by 15 -> 0x0000 with out_z = 1. SLL 0x8001 by 1 -> 0x0002.
- ROR 0x000F by 4 -> 0xF000. ROR 0x1234 by 0 -> 0x1234. Illegal op 11 on 0xABCD by 5 -> out_data = 0xABCD, out_err = 1.
- Back-to-back ops A, B, C with out_ready = 0 for 3 cycles -> A held stable in stage 2, B in stage 1, in_ready = 0, C not accepted. Then out_ready = 1 -> A, B, C delivered in order, one per cycle.
- Pipeline full, flush for 1 cycle with in_valid = 1 -> in_ready = 0, no accept. Next cycle out_valid = 0 and in_ready = 1. A new op then completes with normal 2-cycle latency.
- rst_n pulsed low asynchronously with both stages valid -> out_valid and outputs go to 0 without a clock edge. After release, in_ready = 1 and a new SLL 0x0003 by 2 returns 0x000C.

Source files
------------

// File: rtl/shift_ex_stage_if.sv
// Handshake bundle for the shift execute stage: issue-side request channel
// and writeback-side result channel.
interface shift_ex_stage_if #(
   parameter int unsigned DW = 16,
   parameter int unsigned SW = 4,
   parameter int unsigned TW = 4
);
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic [SW-1:0] in_amt;
   logic [1:0]    in_op;
   logic [TW-1:0] in_tag;

   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [TW-1:0] out_tag;
   logic          out_z;
   logic          out_err;

   // Issue/writeback environment side.
   modport master (
      output in_valid, in_data, in_amt, in_op, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag, out_z, out_err
   );

   // Pipeline side.
   modport slave (
      input  in_valid, in_data, in_amt, in_op, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag, out_z, out_err
   );
endinterface

// File: rtl/shift_ex_stage.sv
// Two-stage elastic execute pipeline for SLL/SRA/ROR: stage 1 holds the issued
// operation, stage 2 holds the computed result with Z/error flags.
module shift_ex_stage #(
   parameter int unsigned DW = 16,
   parameter int unsigned SW = 4,
   parameter int unsigned TW = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   shift_ex_stage_if.slave  bus
);

   typedef enum logic [1:0] {
      OpSll = 2'b00,
      OpSra = 2'b01,
      OpRor = 2'b10,
      OpIll = 2'b11
   } op_e;

   logic          s1_valid_q, s1_valid_d;
   logic [DW-1:0] s1_data_q, s1_data_d;
   logic [SW-1:0] s1_amt_q, s1_amt_d;
   op_e           s1_op_q, s1_op_d;
   logic [TW-1:0] s1_tag_q, s1_tag_d;

   logic          s2_valid_q, s2_valid_d;
   logic [DW-1:0] s2_data_q, s2_data_d;
   logic [TW-1:0] s2_tag_q, s2_tag_d;
   logic          s2_z_q, s2_z_d;
   logic          s2_err_q, s2_err_d;

   logic          s2_free;
   logic          s1_adv;
   logic          in_ready;
   logic          accept;
   logic          deliver;

   logic [DW-1:0] sll_res;
   logic [DW-1:0] sra_res;
   logic [DW-1:0] ror_res;
   logic [DW-1:0] res;
   logic          res_err;

   // out_ready reaches in_ready combinationally so a full pipe can refill while draining.
   always_comb begin
      s2_free  = !s2_valid_q || bus.out_ready;
      s1_adv   = s1_valid_q && s2_free;
      in_ready = !flush && (!s1_valid_q || s1_adv);
      accept   = bus.in_valid && in_ready;
      deliver  = s2_valid_q && bus.out_ready;
   end

   // Log-depth barrel: each amount bit applies a power-of-two shift step.
   always_comb begin
      sll_res = s1_data_q;
      sra_res = s1_data_q;
      ror_res = s1_data_q;
      for (int unsigned i = 0; i < SW; i++) begin
         if (s1_amt_q[i]) begin
            sll_res = sll_res << (1 << i);
            sra_res = $signed(sra_res) >>> (1 << i);
            ror_res = (ror_res >> (1 << i)) | (ror_res << (DW - (1 << i)));
         end
      end
   end

   always_comb begin
      res     = s1_data_q;
      res_err = 1'b0;
      unique case (s1_op_q)
         OpSll: res = sll_res;
         OpSra: res = sra_res;
         OpRor: res = ror_res;
         OpIll: begin
            res     = s1_data_q;
            res_err = 1'b1;
         end
      endcase
   end

   always_comb begin
      s1_data_d = s1_data_q;
      s1_amt_d  = s1_amt_q;
      s1_op_d   = s1_op_q;
      s1_tag_d  = s1_tag_q;
      if (accept) begin
         s1_data_d = bus.in_data;
         s1_amt_d  = bus.in_amt;
         s1_op_d   = op_e'(bus.in_op);
         s1_tag_d  = bus.in_tag;
      end

      if (flush) begin
         s1_valid_d = 1'b0;
      end else if (accept) begin
         s1_valid_d = 1'b1;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end else begin
         s1_valid_d = s1_valid_q;
      end
   end

   always_comb begin
      s2_data_d = s2_data_q;
      s2_tag_d  = s2_tag_q;
      s2_z_d    = s2_z_q;
      s2_err_d  = s2_err_q;
      if (s1_adv) begin
         s2_data_d = res;
         s2_tag_d  = s1_tag_q;
         s2_z_d    = (res == '0);
         s2_err_d  = res_err;
      end

      // A same-edge advance overrides the delivery, replacing the stage-2 contents.
      if (flush) begin
         s2_valid_d = 1'b0;
      end else if (s1_adv) begin
         s2_valid_d = 1'b1;
      end else if (deliver) begin
         s2_valid_d = 1'b0;
      end else begin
         s2_valid_d = s2_valid_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_amt_q   <= '0;
         s1_op_q    <= OpSll;
         s1_tag_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_tag_q   <= '0;
         s2_z_q     <= 1'b0;
         s2_err_q   <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         s1_amt_q   <= s1_amt_d;
         s1_op_q    <= s1_op_d;
         s1_tag_q   <= s1_tag_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_tag_q   <= s2_tag_d;
         s2_z_q     <= s2_z_d;
         s2_err_q   <= s2_err_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = s2_valid_q;
   assign bus.out_data  = s2_data_q;
   assign bus.out_tag   = s2_tag_q;
   assign bus.out_z     = s2_z_q;
   assign bus.out_err   = s2_err_q;

`ifndef SYNTHESIS
   a_flush_empties: assert property (@(posedge clk) disable iff (!rst_n)
      flush |=> !bus.out_valid);

   a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (bus.out_valid && !bus.out_ready && !flush) |=>
         (bus.out_valid && $stable(bus.out_data) && $stable(bus.out_tag) &&
          $stable(bus.out_z) && $stable(bus.out_err)));
`endif

endmodule

// File: tb/tb_shift_ex_stage.sv
// Directed bench for shift_ex_stage: arithmetic reference model with an
// in-order scoreboard, plus hand-computed literal expectations.
module tb_shift_ex_stage;
   localparam int unsigned DW = 16;
   localparam int unsigned SW = 4;
   localparam int unsigned TW = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   int   checks = 0;
   int   errors = 0;

   shift_ex_stage_if #(.DW(DW), .SW(SW), .TW(TW)) bus ();

   shift_ex_stage #(.DW(DW), .SW(SW), .TW(TW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] data;
      logic [3:0]  tag;
      logic        z;
      logic        err;
   } res_t;

   typedef struct {
      logic [1:0]  op;
      logic [15:0] d;
      logic [3:0]  a;
      logic [3:0]  t;
      logic [15:0] exp;
      logic        z;
      logic        err;
   } vec_t;

   res_t        q[$];
   logic [15:0] got[$];

   function automatic res_t model(input logic [1:0] op, input logic [15:0] d,
                                  input logic [3:0] amt, input logic [3:0] tag);
      res_t        r;
      int unsigned v;
      int signed   s;
      logic [31:0] dd;
      r.tag = tag;
      r.err = 1'b0;
      case (op)
         2'b00: begin
            v = 32'(d) * (32'd1 << amt);
            r.data = v[15:0];
         end
         2'b01: begin
            s = d[15] ? int'(32'(d)) - 65536 : int'(32'(d));
            s = s >>> amt;
            r.data = s[15:0];
         end
         2'b10: begin
            dd = {d, d};
            dd = dd >> amt;
            r.data = dd[15:0];
         end
         default: begin
            r.data = d;
            r.err  = 1'b1;
         end
      endcase
      r.z = (r.data == 16'h0000);
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] op, input logic [15:0] d, input logic [3:0] a,
                       input logic [3:0] t, output int waits);
      logic ok;
      ok = 1'b0;
      waits = 0;
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_data  = d;
      bus.in_amt   = a;
      bus.in_tag   = t;
      while (!ok && waits < 20) begin
         @(negedge clk);
         waits++;
         ok = bus.in_ready;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      if (!ok) chk("send_timeout", 32'(ok), 32'(1'b1));
   endtask

   task automatic expect_out(input string name, input res_t exp, output int waits);
      logic ok;
      res_t cur;
      ok = 1'b0;
      waits = 0;
      while (!ok && waits < 20) begin
         @(negedge clk);
         waits++;
         ok = bus.out_valid;
      end
      if (!ok) begin
         chk({name, "_timeout"}, 32'(ok), 32'(1'b1));
      end else begin
         cur.data = bus.out_data;
         cur.tag  = bus.out_tag;
         cur.z    = bus.out_z;
         cur.err  = bus.out_err;
         chk(name, 32'(cur), 32'(exp));
      end
   endtask

   // Scoreboard: one pass per cycle, sampled mid-cycle.
   initial begin
      logic prev_stall;
      res_t prev_out;
      prev_stall = 1'b0;
      prev_out   = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            q.delete();
            prev_stall = 1'b0;
         end else begin
            res_t cur;
            cur.data = bus.out_data;
            cur.tag  = bus.out_tag;
            cur.z    = bus.out_z;
            cur.err  = bus.out_err;
            if (prev_stall) begin
               chk("hold_valid", 32'(bus.out_valid), 32'(1'b1));
               chk("hold_stable", 32'(cur), 32'(prev_out));
            end
            if (q.size() == 0) chk("idle_valid", 32'(bus.out_valid), 32'(1'b0));
            if (bus.out_valid && bus.out_ready && q.size() > 0) begin
               chk("result", 32'(cur), 32'(q[0]));
               got.push_back(cur.data);
               void'(q.pop_front());
            end
            if (flush) q.delete();
            if (bus.in_valid && bus.in_ready)
               q.push_back(model(bus.in_op, bus.in_data, bus.in_amt, bus.in_tag));
            prev_stall = bus.out_valid && !bus.out_ready && !flush;
            prev_out   = cur;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs[10];
      res_t e;
      int   w;
      logic ok;

      vecs[0] = '{2'b00, 16'h0001, 4'd4,  4'd3, 16'h0010, 1'b0, 1'b0};
      vecs[1] = '{2'b01, 16'h8000, 4'd15, 4'd1, 16'hFFFF, 1'b0, 1'b0};
      vecs[2] = '{2'b01, 16'h7FFF, 4'd15, 4'd2, 16'h0000, 1'b1, 1'b0};
      vecs[3] = '{2'b00, 16'h8001, 4'd1,  4'd4, 16'h0002, 1'b0, 1'b0};
      vecs[4] = '{2'b10, 16'h000F, 4'd4,  4'd5, 16'hF000, 1'b0, 1'b0};
      vecs[5] = '{2'b10, 16'h1234, 4'd0,  4'd6, 16'h1234, 1'b0, 1'b0};
      vecs[6] = '{2'b11, 16'hABCD, 4'd5,  4'd7, 16'hABCD, 1'b0, 1'b1};
      vecs[7] = '{2'b11, 16'h0000, 4'd3,  4'd8, 16'h0000, 1'b1, 1'b1};
      vecs[8] = '{2'b01, 16'h1234, 4'd0,  4'd9, 16'h1234, 1'b0, 1'b0};
      vecs[9] = '{2'b01, 16'hF0F0, 4'd4,  4'hA, 16'hFF0F, 1'b0, 1'b0};

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_amt    = '0;
      bus.in_op     = '0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b0;

      // Reset state.
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'(1'b0));
      chk("rst_out_data", 32'(bus.out_data), 32'h0);
      chk("rst_out_tag", 32'(bus.out_tag), 32'h0);
      chk("rst_out_z", 32'(bus.out_z), 32'(1'b0));
      chk("rst_out_err", 32'(bus.out_err), 32'(1'b0));
      #11 rst_n = 1'b1;
      step();
      chk("rst_in_ready", 32'(bus.in_ready), 32'(1'b1));

      // Single ops, two-cycle latency, literal results.
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         e.data = vecs[i].exp;
         e.tag  = vecs[i].t;
         e.z    = vecs[i].z;
         e.err  = vecs[i].err;
         chk($sformatf("model_vec%0d", i),
             32'(model(vecs[i].op, vecs[i].d, vecs[i].a, vecs[i].t)), 32'(e));
         send(vecs[i].op, vecs[i].d, vecs[i].a, vecs[i].t, w);
         expect_out($sformatf("vec%0d", i), e, w);
         chk($sformatf("latency_vec%0d", i), 32'(w), 32'd2);
         step();
      end

      // Back-to-back throughput with out_ready high.
      got.delete();
      send(2'b00, 16'h0101, 4'd8, 4'd1, w);
      send(2'b10, 16'h8001, 4'd1, 4'd2, w);
      chk("thru_b_wait", 32'(w), 32'd1);
      send(2'b01, 16'h4000, 4'd2, 4'd3, w);
      chk("thru_c_wait", 32'(w), 32'd1);
      repeat (4) step();
      chk("thru_count", 32'(got.size()), 32'd3);
      if (got.size() == 3) begin
         chk("thru_a", 32'(got[0]), 32'h0100);
         chk("thru_b", 32'(got[1]), 32'hC000);
         chk("thru_c", 32'(got[2]), 32'h1000);
      end

      // Stall with both stages full; C waits, then all drain in order.
      got.delete();
      bus.out_ready = 1'b0;
      send(2'b10, 16'h00F0, 4'd4, 4'd4, w);
      send(2'b00, 16'h0003, 4'd3, 4'd5, w);
      bus.in_valid = 1'b1;
      bus.in_op    = 2'b01;
      bus.in_data  = 16'h8000;
      bus.in_amt   = 4'd1;
      bus.in_tag   = 4'd6;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_in_ready", 32'(bus.in_ready), 32'(1'b0));
         chk("stall_out_valid", 32'(bus.out_valid), 32'(1'b1));
         chk("stall_out_data", 32'(bus.out_data), 32'h000F);
         step();
      end
      bus.out_ready = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 5 && !ok; i++) begin
         @(negedge clk);
         ok = bus.in_ready;
         step();
      end
      bus.in_valid = 1'b0;
      chk("stall_c_accept", 32'(ok), 32'(1'b1));
      repeat (4) step();
      chk("stall_count", 32'(got.size()), 32'd3);
      if (got.size() == 3) begin
         chk("stall_a", 32'(got[0]), 32'h000F);
         chk("stall_b", 32'(got[1]), 32'h0018);
         chk("stall_c", 32'(got[2]), 32'hC000);
      end

      // Flush a full pipeline while an op is offered.
      got.delete();
      bus.out_ready = 1'b0;
      send(2'b00, 16'h0001, 4'd1, 4'd1, w);
      send(2'b00, 16'h0001, 4'd2, 4'd2, w);
      flush        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h5555;
      @(negedge clk);
      chk("flush_in_ready", 32'(bus.in_ready), 32'(1'b0));
      step();
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("post_flush_valid", 32'(bus.out_valid), 32'(1'b0));
      chk("post_flush_ready", 32'(bus.in_ready), 32'(1'b1));
      step();
      bus.out_ready = 1'b1;
      e = '{data: 16'h8000, tag: 4'd9, z: 1'b0, err: 1'b0};
      send(2'b10, 16'h0001, 4'd1, 4'd9, w);
      expect_out("post_flush_op", e, w);
      chk("post_flush_latency", 32'(w), 32'd2);
      repeat (2) step();
      chk("flush_count", 32'(got.size()), 32'd1);

      // Asynchronous reset with both stages valid.
      bus.out_ready = 1'b0;
      send(2'b00, 16'h00FF, 4'd4, 4'hC, w);
      send(2'b10, 16'h0F00, 4'd8, 4'hD, w);
      chk("pre_rst_valid", 32'(bus.out_valid), 32'(1'b1));
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(bus.out_valid), 32'(1'b0));
      chk("arst_out_data", 32'(bus.out_data), 32'h0);
      chk("arst_out_tag", 32'(bus.out_tag), 32'h0);
      chk("arst_out_z", 32'(bus.out_z), 32'(1'b0));
      chk("arst_out_err", 32'(bus.out_err), 32'(1'b0));
      #10 rst_n = 1'b1;
      step();
      chk("arst_in_ready", 32'(bus.in_ready), 32'(1'b1));
      chk("arst_idle_valid", 32'(bus.out_valid), 32'(1'b0));
      bus.out_ready = 1'b1;
      e = '{data: 16'h000C, tag: 4'd1, z: 1'b0, err: 1'b0};
      send(2'b00, 16'h0003, 4'd2, 4'd1, w);
      expect_out("arst_resume", e, w);
      chk("arst_resume_latency", 32'(w), 32'd2);
      repeat (2) step();
      chk("drain_empty", 32'(q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
